block_data_memory: RTL and testbench
====================================

# block_data_memory

Block-granular main memory that acts as the responder on the cache-to-main-memory interface: it accepts one 32-bit block read or write per request, holds busywait high for a fixed multi-cycle latency, then completes the access. It sits below the data cache controller and stores 64 blocks of 4 bytes (256 bytes total). It models slow DRAM timing so cache miss and write-back paths can be exercised cycle-accurately.

## Interface
- LATENCY, 5: clock cycles from request acceptance to completion; legal range 1..255.
- ADDR_W, 6: block address width; depth = 2**ADDR_W blocks.
- DATA_W, 32: block width in bits.
- clock  in  1  system clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears state, counter, readdata and the whole array.
- read  in  1  block read request; held by initiator until it sees busywait low.
- write  in  1  block write request; same hold rule.
- address  in  ADDR_W  block address ({tag, index} for fills, {stored tag, index} for write-backs).
- writedata  in  DATA_W  block to store on write.
- readdata  out  DATA_W  block returned on read; registered, reset 0.
- busywait  out  1  high while a request is pending and not complete; reset 0.

## Operation
- States: IDLE, BUSY, DONE; encoding 2'b00, 2'b01, 2'b10.
- Valid request = read XOR write. read and write both high is illegal: treated as no request, no access, busywait low, state stays IDLE.
- IDLE: busywait = valid request (combinational from inputs, so it rises in the same cycle the request appears). On a rising edge with a valid request: latch op, address, writedata; load counter with LATENCY-1; go BUSY.
- BUSY: busywait = 1. Counter decrements each edge. On the edge where counter = 0: perform access (write: array[addr_q] <= wdata_q; read: readdata <= array[addr_q]); go DONE.
- DONE: busywait = 0 for exactly one cycle; go IDLE on next edge regardless of inputs. Initiator samples readdata / deasserts request in this cycle.
- If request is still (or newly) asserted in IDLE after DONE, it is a new access.
- Request inputs changing or dropping during BUSY are ignored; latched values are used and the access always completes.
- readdata holds its last read value across writes and idle periods; never updated by writes.
- Array has no byte enables; full-block writes only.

## Timing
- Request accepted at edge T0 (first edge in IDLE with valid request).
- Completion edge: T0+LATENCY; array/readdata updated there.
- busywait high from request assertion until T0+LATENCY; low during cycle T0+LATENCY..T0+LATENCY+1.
- Back-to-back: next request accepted no earlier than T0+LATENCY+2; throughput one access per LATENCY+2 cycles.
- Read-after-write to same block returns the new data.
- Reset at any time: state IDLE, counter 0, busywait 0, readdata 0, array all zero; in-flight write is discarded (array not updated). First request after reset deassertion is accepted on the first rising edge with reset low.
- LATENCY=1: BUSY lasts one cycle (counter loaded 0, completes next edge).

## Structure
- Shared package mem_pkg: state enum/constants (IDLE, BUSY, DONE), default LATENCY, BLOCK_ADDR_W=6, BLOCK_DATA_W=32, so the cache controller and this block agree on interface widths.
- One sub-module is natural: mem_latency_counter (load, decrement, zero flag, width $clog2(LATENCY+1)); the array and FSM stay in the top.

## Test plan
- Reset then read address 6'h00 -> busywait high 5 cycles, readdata = 32'h0000_0000 in DONE cycle.
- Write 32'hDEAD_BEEF to 6'h15, then read 6'h15 -> write busy 5 cycles; read returns 32'hDEAD_BEEF, readdata holds it until next read.
- Write 32'h1234_5678 to 6'h3F, drop write and change address to 6'h01 mid-BUSY -> 6'h3F holds 32'h1234_5678, 6'h01 unchanged, completion still at T0+5.
- Hold read to 6'h02 asserted continuously -> accesses at T0, T0+7, T0+14; busywait low exactly one cycle each.
- Assert read and write together -> busywait stays 0, no array change, state IDLE.
- Write 32'hAAAA_5555 to 6'h10, pulse reset at T0+3 -> busywait 0 immediately, 6'h10 reads 32'h0 afterwards.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the cache-to-main-memory interface.
// Keeps the cache controller and the block memory agreed on widths and FSM encoding.
package mem_pkg;

    localparam int unsigned BLOCK_ADDR_W    = 6;
    localparam int unsigned BLOCK_DATA_W    = 32;
    localparam int unsigned DEFAULT_LATENCY = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

    // Asserting read and write together is not a request at all.
    function automatic logic valid_request(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter that times the access latency; zero_c marks the completion cycle.
module mem_latency_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_value,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/block_data_memory.sv
// Block-granular main memory with fixed multi-cycle latency, responder on the
// cache-to-memory interface: one full-block read or write per request.
module block_data_memory
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = DEFAULT_LATENCY,
    parameter int unsigned ADDR_W  = BLOCK_ADDR_W,
    parameter int unsigned DATA_W  = BLOCK_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              busywait
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    mem_state_e        state;
    mem_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem_array [DEPTH];

    logic req_valid_c;
    logic load_c;
    logic dec_c;
    logic cnt_zero_c;
    logic complete_c;

    assign req_valid_c = valid_request(read, write);
    assign load_c      = (state == IDLE) && req_valid_c;
    assign dec_c       = (state == BUSY);
    assign complete_c  = (state == BUSY) && cnt_zero_c;

    mem_latency_counter #(
        .W(CNT_W)
    ) u_latency_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (load_c),
        .dec        (dec_c),
        .load_value (CNT_W'(LATENCY - 1)),
        .zero_c     (cnt_zero_c)
    );

    // In IDLE busywait follows the request combinationally so it rises in the request cycle.
    always_comb begin
        busywait = 1'b0;
        case (state)
            IDLE:    busywait = req_valid_c;
            BUSY:    busywait = 1'b1;
            default: busywait = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            readdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_c) begin
                        op_q    <= write ? OP_WRITE : OP_READ;
                        addr_q  <= address;
                        wdata_q <= writedata;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_zero_c) begin
                        if (op_q == OP_READ) begin
                            readdata <= mem_array[addr_q];
                        end
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Reset clears the whole array, so an in-flight write is simply lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_array[i] <= '0;
            end
        end else if (complete_c && (op_q == OP_WRITE)) begin
            mem_array[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: vector table plus multi-cycle corner sequences.
module tb_block_data_memory;

    logic        clock = 1'b0;
    logic        reset;
    logic        read, write;
    logic [5:0]  address;
    logic [31:0] writedata, readdata;
    logic        busywait;

    logic        read1, write1;
    logic [5:0]  address1;
    logic [31:0] writedata1, readdata1;
    logic        busywait1;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    block_data_memory #(.LATENCY(5)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .busywait  (busywait)
    );

    block_data_memory #(.LATENCY(1)) u_dut_lat1 (
        .clock     (clock),
        .reset     (reset),
        .read      (read1),
        .write     (write1),
        .address   (address1),
        .writedata (writedata1),
        .readdata  (readdata1),
        .busywait  (busywait1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          exp_busy;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on the LATENCY=5 instance; busy counts negedge samples with busywait high.
    task automatic access(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] wd,
                          output int busy, output logic [31:0] rdat, output logic comb_busy);
        @(negedge clock);
        read = rd; write = wr; address = a; writedata = wd;
        #1 comb_busy = busywait;
        busy = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (!busywait) break;
            busy++;
        end
        rdat = readdata;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic access1(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] wd,
                           output int busy, output logic [31:0] rdat);
        @(negedge clock);
        read1 = rd; write1 = wr; address1 = a; writedata1 = wd;
        busy = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (!busywait1) break;
            busy++;
        end
        rdat = readdata1;
        read1 = 1'b0; write1 = 1'b0;
    endtask

    initial begin
        int          busy;
        logic [31:0] rdat;
        logic        cb;
        logic [20:0] pat, exp_pat;
        logic [31:0] rd_at5;

        vecs[0] = '{1'b1, 1'b0, 6'h00, 32'h0,           5, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b1, 6'h15, 32'hDEAD_BEEF,   5, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 6'h15, 32'h0,           5, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b1, 6'h3F, 32'h5A5A_0001,   5, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b1, 6'h00, 32'hCAFE_F00D,   5, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b0, 6'h3F, 32'h0,           5, 32'h5A5A_0001};
        vecs[6] = '{1'b1, 1'b0, 6'h00, 32'h0,           5, 32'hCAFE_F00D};
        vecs[7] = '{1'b1, 1'b1, 6'h15, 32'h0000_0000,   0, 32'hCAFE_F00D};
        vecs[8] = '{1'b1, 1'b0, 6'h15, 32'h0,           5, 32'hDEAD_BEEF};
        vecs[9] = '{1'b1, 1'b0, 6'h01, 32'h0,           5, 32'h0000_0000};

        reset = 1'b1;
        read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        read1 = 1'b0; write1 = 1'b0; address1 = '0; writedata1 = '0;
        repeat (2) @(negedge clock);
        check("reset_busywait", 32'(busywait), 32'h0);
        check("reset_readdata", readdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, busy, rdat, cb);
            check($sformatf("vec%0d_comb_busy", i), 32'(cb), 32'(vecs[i].exp_busy != 0));
            check($sformatf("vec%0d_busy_cycles", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_readdata", i), rdat, vecs[i].exp_rdata);
        end

        // Drop write and change address while BUSY; latched values must still complete.
        @(negedge clock);
        write = 1'b1; address = 6'h3F; writedata = 32'h1234_5678;
        busy = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (!busywait) break;
            busy++;
            if (busy == 2) begin
                write = 1'b0; address = 6'h01; writedata = 32'hFFFF_FFFF;
            end
        end
        check("midbusy_busy_cycles", 32'(busy), 32'd5);
        access(1'b1, 1'b0, 6'h3F, 32'h0, busy, rdat, cb);
        check("midbusy_3f", rdat, 32'h1234_5678);
        access(1'b1, 1'b0, 6'h01, 32'h0, busy, rdat, cb);
        check("midbusy_01", rdat, 32'h0000_0000);

        // Held read: accepts every 7 cycles, busywait low one cycle each time.
        access(1'b0, 1'b1, 6'h02, 32'h0000_0202, busy, rdat, cb);
        @(negedge clock);
        read = 1'b1; address = 6'h02;
        rd_at5 = '0;
        for (int k = 0; k < 21; k++) begin
            @(negedge clock);
            pat[k] = busywait;
            exp_pat[k] = ((k % 7) != 5);
            if (k == 5) rd_at5 = readdata;
        end
        read = 1'b0;
        check("held_read_pattern", 32'(pat), 32'(exp_pat));
        check("held_read_data", rd_at5, 32'h0000_0202);

        // Reset in the middle of a write discards it and clears the array.
        @(negedge clock);
        write = 1'b1; address = 6'h10; writedata = 32'hAAAA_5555;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        write = 1'b0;
        #1;
        check("midreset_busywait", 32'(busywait), 32'h0);
        check("midreset_readdata", readdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        access(1'b1, 1'b0, 6'h10, 32'h0, busy, rdat, cb);
        check("postreset_busy_cycles", 32'(busy), 32'd5);
        check("postreset_10", rdat, 32'h0);
        access(1'b1, 1'b0, 6'h3F, 32'h0, busy, rdat, cb);
        check("postreset_3f", rdat, 32'h0);

        // LATENCY=1 instance: single BUSY cycle.
        access1(1'b0, 1'b1, 6'h07, 32'h1111_2222, busy, rdat);
        check("lat1_write_busy", 32'(busy), 32'd1);
        access1(1'b1, 1'b0, 6'h07, 32'h0, busy, rdat);
        check("lat1_read_busy", 32'(busy), 32'd1);
        check("lat1_read_data", rdat, 32'h1111_2222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
